pll_reset_sequencer: RTL and testbench
======================================

Name: pll_reset_sequencer

Overview:
Sequences the iCE40 PLL that turns clk_12MHz into clk_36MHz. Pulses the PLL RESETB, waits for LOCK with timeout and retry, qualifies lock stability, then releases a synchronous-deassert system reset and a clock enable for the 36 MHz video/game logic. Runs entirely on the 12 MHz reference clock, so it is independent of PLL output health. Monitors lock loss and soft-reset requests during operation.

Parameters:
RESET_CYCLES, 16, clk_12MHz cycles pll_resetb is held low per attempt (min 1)
LOCK_TIMEOUT, 12000, cycles allowed in WAIT_LOCK before retry (1 ms)
STABLE_CYCLES, 1200, consecutive locked cycles required before release (100 us)
MAX_RETRIES, 3, failed lock attempts tolerated before FAULT
CNT_W, 16, width of the shared cycle counter; must hold max(RESET_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES)

Ports:
clk_12MHz  input  1  reference clock, sole clock of the block
rst_n  input  1  asynchronous active-low reset
pll_locked  input  1  PLL LOCK, asynchronous to clk_12MHz
soft_reset_req  input  1  single-cycle request to re-run the full sequence
pll_resetb  output  1  to PLL RESETB; 0 = PLL held in reset
sys_reset_n  output  1  system reset for downstream logic, 0 = reset
clk_en  output  1  enable for downstream clock gating / logic
ready  output  1  1 only in RUN
fault  output  1  sticky: retries exhausted
state  output  3  encoded FSM state for debug
relock_count  output  8  saturating count of lock losses observed in RUN

Behaviour:
- Reset (rst_n=0, async): state=PLL_RST, pll_resetb=0, sys_reset_n=0, clk_en=0, ready=0, fault=0, relock_count=0, counter=0, retry=0.
- pll_locked passes a 2-FF synchronizer; all decisions use lock_s (2-cycle latency).
- All outputs registered; change one cycle after the state transition that determines them.
- States (encoding): PLL_RST=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAULT=4.
- PLL_RST: pll_resetb=0. Counter counts to RESET_CYCLES-1, then clear counter -> WAIT_LOCK.
- WAIT_LOCK: pll_resetb=1. lock_s=1 -> clear counter, -> STABLE. Counter reaching LOCK_TIMEOUT-1 with lock_s=0 -> retry+1; if retry was MAX_RETRIES-1 -> FAULT, else -> PLL_RST. Lock seen in the timeout cycle wins (-> STABLE).
- STABLE: lock_s=0 at any cycle -> clear counter, -> WAIT_LOCK (timeout restarts, retry unchanged). Counter reaching STABLE_CYCLES-1 with lock_s=1 -> retry=0, -> RUN.
- RUN: sys_reset_n=1, clk_en=1, ready=1. lock_s=0 -> relock_count+1 (saturate at 255), -> PLL_RST. soft_reset_req=1 -> PLL_RST, relock_count unchanged. Both simultaneously: lock loss wins (count increments).
- sys_reset_n, clk_en, ready: 0 in every state except RUN; drop in the first cycle after leaving RUN (assert immediate, release only via STABLE).
- FAULT: pll_resetb=0, fault=1, all else deasserted; exit only via rst_n. soft_reset_req ignored.
- soft_reset_req outside RUN and FAULT: ignored.
- rst_n asserted mid-sequence: immediate return to reset values; counters and retry cleared.
- Counter never wraps: cleared on every state entry.

Decomposition:
- Package pll_seq_pkg: state enum/localparams (PLL_RST..FAULT), STATE_W=3, RELOCK_W=8.
- Sub-module sync_2ff (parameterised width, async active-low reset to 0) for pll_locked; reusable for other async inputs.
- Counter and FSM stay in pll_reset_sequencer.

Test Plan:
- Params RESET_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8; lock rises 5 cycles after pll_resetb=1 -> pll_resetb low exactly 4 cycles, ready=1 and sys_reset_n=1 at cycle 4+5+2+8+1 (+-1 per registering as specified), relock_count=0.
- Lock never asserts, MAX_RETRIES=3 -> three 4-cycle pll_resetb pulses 20 cycles apart, then fault=1, state=4, pll_resetb=0 held.
- Lock glitches low 1 cycle (>= sync) at STABLE count 6 -> returns to WAIT_LOCK, release delayed by a full 8 further stable cycles.
- In RUN drop lock -> sys_reset_n=0, clk_en=0 within 3 cycles of pll_locked fall, relock_count=1, full sequence reruns; repeat 300 times -> relock_count=255.
- In RUN pulse soft_reset_req with lock held -> PLL_RST next cycle, relock_count unchanged; same cycle with lock loss -> relock_count increments.
- Assert rst_n low mid-STABLE and mid-FAULT -> all outputs at reset values asynchronously, fault cleared.

Source files
------------

// File: rtl/pll_seq_pkg.sv
// Shared types and widths for the PLL reset sequencer.
// State encoding is visible on the debug port, so the values are fixed.
package pll_seq_pkg;

  localparam int STATE_W  = 3;
  localparam int RELOCK_W = 8;

  typedef enum logic [STATE_W-1:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } pll_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for slow asynchronous level inputs.
// Resets to zero, so a synchronized input always reads inactive out of reset.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// Brings up the iCE40 PLL from the 12 MHz reference: reset pulse, lock wait with
// retry, lock qualification, then release of the downstream reset and clock enable.
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int RESET_CYCLES  = 16,
  parameter int LOCK_TIMEOUT  = 12000,
  parameter int STABLE_CYCLES = 1200,
  parameter int MAX_RETRIES   = 3,
  parameter int CNT_W         = 16
) (
  input  logic                clk_12MHz,
  input  logic                rst_n,
  input  logic                pll_locked,
  input  logic                soft_reset_req,
  output logic                pll_resetb,
  output logic                sys_reset_n,
  output logic                clk_en,
  output logic                ready,
  output logic                fault,
  output logic [STATE_W-1:0]  state,
  output logic [RELOCK_W-1:0] relock_count
);

  localparam int RETRY_W = $clog2(MAX_RETRIES + 1);

  localparam logic [CNT_W-1:0]   RESET_LAST   = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_LAST   = RETRY_W'(MAX_RETRIES - 1);

  logic                lock_s;
  pll_state_e          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [RETRY_W-1:0]  retry_q, retry_d;
  logic [RELOCK_W-1:0] relock_q, relock_d;
  logic                pll_resetb_q, sys_reset_n_q, clk_en_q, ready_q, fault_q;

  sync_2ff #(.WIDTH(1)) u_lock_sync (
    .clk_i  (clk_12MHz),
    .rst_ni (rst_n),
    .d_i    (pll_locked),
    .q_o    (lock_s)
  );

  // The cycle counter is shared by all timed states and cleared on every entry.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + 1'b1;
    retry_d  = retry_q;
    relock_d = relock_q;
    unique case (state_q)
      PLL_RST: begin
        if (cnt_q == RESET_LAST) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end
      end
      WAIT_LOCK: begin
        if (lock_s) begin
          state_d = STABLE;
          cnt_d   = '0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          cnt_d   = '0;
          retry_d = retry_q + 1'b1;
          state_d = (retry_q == RETRY_LAST) ? FAULT : PLL_RST;
        end
      end
      STABLE: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
          retry_d = '0;
        end
      end
      RUN: begin
        cnt_d = '0;
        // Lock loss takes priority over a simultaneous soft request so it is always counted.
        if (!lock_s) begin
          state_d = PLL_RST;
          if (relock_q != '1) relock_d = relock_q + 1'b1;
        end else if (soft_reset_req) begin
          state_d = PLL_RST;
        end
      end
      FAULT: begin
        cnt_d = '0;
      end
      default: begin
        state_d = PLL_RST;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they register alongside it.
  always_ff @(posedge clk_12MHz or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= PLL_RST;
      cnt_q         <= '0;
      retry_q       <= '0;
      relock_q      <= '0;
      pll_resetb_q  <= 1'b0;
      sys_reset_n_q <= 1'b0;
      clk_en_q      <= 1'b0;
      ready_q       <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      retry_q       <= retry_d;
      relock_q      <= relock_d;
      pll_resetb_q  <= (state_d == WAIT_LOCK) || (state_d == STABLE) || (state_d == RUN);
      sys_reset_n_q <= (state_d == RUN);
      clk_en_q      <= (state_d == RUN);
      ready_q       <= (state_d == RUN);
      fault_q       <= (state_d == FAULT);
    end
  end

  assign pll_resetb   = pll_resetb_q;
  assign sys_reset_n  = sys_reset_n_q;
  assign clk_en       = clk_en_q;
  assign ready        = ready_q;
  assign fault        = fault_q;
  assign state        = state_q;
  assign relock_count = relock_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Self-checking bench for pll_reset_sequencer: directed bring-up, retry, glitch,
// relock and reset scenarios plus randomized lock/soft-reset traffic against a phase model.
module tb_pll_reset_sequencer;

  localparam int RESET_CYCLES  = 4;
  localparam int LOCK_TIMEOUT  = 20;
  localparam int STABLE_CYCLES = 8;
  localparam int MAX_RETRIES   = 3;

  localparam int PH_RST    = 0;
  localparam int PH_WAIT   = 1;
  localparam int PH_STABLE = 2;
  localparam int PH_RUN    = 3;
  localparam int PH_FAULT  = 4;

  logic       clk_12MHz = 1'b0;
  logic       rst_n;
  logic       pll_locked;
  logic       soft_reset_req;
  logic       pll_resetb;
  logic       sys_reset_n;
  logic       clk_en;
  logic       ready;
  logic       fault;
  logic [2:0] state;
  logic [7:0] relock_count;

  int checks = 0;
  int errors = 0;

  // Reference model: current phase, cycles spent in it, failed attempts, lock losses,
  // and the two-stage delay of the lock input.
  int mPhase;
  int mElapsed;
  int mRetry;
  int mRelock;
  bit mMeta;
  bit mLockS;

  always #5 clk_12MHz = ~clk_12MHz;

  pll_reset_sequencer #(
    .RESET_CYCLES  (RESET_CYCLES),
    .LOCK_TIMEOUT  (LOCK_TIMEOUT),
    .STABLE_CYCLES (STABLE_CYCLES),
    .MAX_RETRIES   (MAX_RETRIES),
    .CNT_W         (16)
  ) dut (
    .clk_12MHz      (clk_12MHz),
    .rst_n          (rst_n),
    .pll_locked     (pll_locked),
    .soft_reset_req (soft_reset_req),
    .pll_resetb     (pll_resetb),
    .sys_reset_n    (sys_reset_n),
    .clk_en         (clk_en),
    .ready          (ready),
    .fault          (fault),
    .state          (state),
    .relock_count   (relock_count)
  );

  function automatic void modelReset();
    mPhase   = PH_RST;
    mElapsed = 0;
    mRetry   = 0;
    mRelock  = 0;
    mMeta    = 1'b0;
    mLockS   = 1'b0;
  endfunction

  function automatic void enterPhase(input int p);
    mPhase   = p;
    mElapsed = 0;
  endfunction

  // Advances the model by one reference clock using the lock value seen through the synchronizer.
  function automatic void modelStep(input bit lockIn, input bit softIn);
    bit ls;
    ls     = mLockS;
    mLockS = mMeta;
    mMeta  = lockIn;
    case (mPhase)
      PH_RST: begin
        mElapsed++;
        if (mElapsed == RESET_CYCLES) enterPhase(PH_WAIT);
      end
      PH_WAIT: begin
        if (ls) enterPhase(PH_STABLE);
        else begin
          mElapsed++;
          if (mElapsed == LOCK_TIMEOUT) begin
            mRetry++;
            enterPhase((mRetry == MAX_RETRIES) ? PH_FAULT : PH_RST);
          end
        end
      end
      PH_STABLE: begin
        if (!ls) enterPhase(PH_WAIT);
        else begin
          mElapsed++;
          if (mElapsed == STABLE_CYCLES) begin
            mRetry = 0;
            enterPhase(PH_RUN);
          end
        end
      end
      PH_RUN: begin
        if (!ls) begin
          if (mRelock < 255) mRelock++;
          enterPhase(PH_RST);
        end else if (softIn) begin
          enterPhase(PH_RST);
        end
      end
      default: ;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkAllOutputs();
    checkOutput("state", 32'(state), mPhase);
    checkOutput("pll_resetb", 32'(pll_resetb),
                32'((mPhase == PH_WAIT) || (mPhase == PH_STABLE) || (mPhase == PH_RUN)));
    checkOutput("sys_reset_n", 32'(sys_reset_n), 32'(mPhase == PH_RUN));
    checkOutput("clk_en", 32'(clk_en), 32'(mPhase == PH_RUN));
    checkOutput("ready", 32'(ready), 32'(mPhase == PH_RUN));
    checkOutput("fault", 32'(fault), 32'(mPhase == PH_FAULT));
    checkOutput("relock_count", 32'(relock_count), mRelock);
  endtask

  // Checks the state left by the previous edge, then drives inputs for the next edge.
  task automatic applyStimulus(input bit lockIn, input bit softIn);
    @(negedge clk_12MHz);
    checkAllOutputs();
    rst_n          = 1'b1;
    pll_locked     = lockIn;
    soft_reset_req = softIn;
    modelStep(lockIn, softIn);
  endtask

  // Asserts rst_n between clock edges and leaves it asserted; the next applyStimulus releases it.
  task automatic asyncReset();
    @(negedge clk_12MHz);
    #2;
    rst_n = 1'b0;
    modelReset();
    #1;
    checkAllOutputs();
    @(posedge clk_12MHz);
    #1;
    checkAllOutputs();
  endtask

  task automatic waitReady(input int maxDelay, input string tag);
    int d;
    int n;
    d = int'($urandom_range(0, maxDelay));
    n = 0;
    while (ready !== 1'b1 && n < 200) begin
      applyStimulus(n >= d, 1'b0);
      n++;
    end
    checkOutput(tag, 32'(ready), 32'd1);
  endtask

  initial begin
    int n;
    int dl;

    rst_n          = 1'b1;
    pll_locked     = 1'b0;
    soft_reset_req = 1'b0;
    modelReset();
    #2;
    rst_n = 1'b0;
    @(negedge clk_12MHz);
    checkAllOutputs();

    // Nominal bring-up: lock rises 5 cycles after RESETB release.
    for (int k = 1; k <= 19; k++) applyStimulus(k >= 9, 1'b0);
    checkOutput("ready_before_release", 32'(ready), 32'd0);
    applyStimulus(1'b1, 1'b0);
    checkOutput("ready_at_release", 32'(ready), 32'd1);
    checkOutput("sysrst_at_release", 32'(sys_reset_n), 32'd1);
    checkOutput("relock_initial", 32'(relock_count), 32'd0);

    // Soft reset with lock held.
    repeat (3) applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0);
    checkOutput("soft_to_pll_rst", 32'(state), 32'd0);
    checkOutput("soft_relock_unchanged", 32'(relock_count), 32'd0);
    waitReady(0, "ready_after_soft");

    // Lock loss coinciding with a soft request; outputs drop 3 edges after the lock falls.
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("run_before_loss_seen", 32'(ready), 32'd1);
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0);
    checkOutput("relock_on_combined", 32'(relock_count), 32'd1);
    checkOutput("sysrst_drop_3cyc", 32'(sys_reset_n), 32'd0);
    checkOutput("clken_drop_3cyc", 32'(clk_en), 32'd0);

    // Repeated lock losses with randomized lock return (some attempts time out once).
    for (int i = 0; i < 300; i++) begin
      waitReady(30, "ready_in_loop");
      if (i == 10) checkOutput("relock_count_mid", 32'(relock_count), 32'd11);
      repeat ($urandom_range(0, 3)) applyStimulus(1'b1, 1'b0);
      dl = int'($urandom_range(1, 3));
      repeat (dl) applyStimulus(1'b0, 1'b0);
      n = 0;
      while (ready !== 1'b0 && n < 10) begin
        applyStimulus(1'b0, 1'b0);
        n++;
      end
      checkOutput("ready_drop_in_loop", 32'(ready), 32'd0);
    end
    checkOutput("relock_saturated", 32'(relock_count), 32'd255);
    waitReady(0, "ready_after_loop");
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0);
    checkOutput("soft_keeps_saturated", 32'(relock_count), 32'd255);

    asyncReset();
    checkOutput("relock_cleared", 32'(relock_count), 32'd0);

    // One-cycle lock glitch at STABLE count 6 pushes release out by a full qualification.
    n = 0;
    while (state !== 3'd2 && n < 50) begin
      applyStimulus(1'b1, 1'b0);
      n++;
    end
    checkOutput("reach_stable", 32'(state), 32'd2);
    repeat (3) applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    n = 0;
    while (ready !== 1'b1 && n < 40) begin
      applyStimulus(1'b1, 1'b0);
      n++;
    end
    checkOutput("glitch_release_delay", n, 32'd12);

    // Reset in the middle of STABLE.
    applyStimulus(1'b1, 1'b1);
    n = 0;
    while (state !== 3'd2 && n < 50) begin
      applyStimulus(1'b1, 1'b0);
      n++;
    end
    checkOutput("reach_stable_again", 32'(state), 32'd2);
    repeat (3) applyStimulus(1'b1, 1'b0);
    asyncReset();
    checkOutput("mid_stable_reset_state", 32'(state), 32'd0);
    checkOutput("mid_stable_reset_resetb", 32'(pll_resetb), 32'd0);

    // Lock never arrives: three attempts, then FAULT.
    n = 0;
    while (fault !== 1'b1 && n < 200) begin
      applyStimulus(1'b0, 1'b0);
      n++;
    end
    checkOutput("fault_latency", n, 32'd73);
    checkOutput("fault_state", 32'(state), 32'd4);
    checkOutput("fault_resetb_low", 32'(pll_resetb), 32'd0);
    for (int k = 0; k < 30; k++) applyStimulus(1'b1, $urandom_range(0, 1) == 1);
    checkOutput("fault_sticky", 32'(fault), 32'd1);
    checkOutput("fault_state_sticky", 32'(state), 32'd4);
    asyncReset();
    checkOutput("fault_cleared", 32'(fault), 32'd0);

    // Randomized lock and soft-reset traffic.
    for (int k = 0; k < 1500; k++)
      applyStimulus($urandom_range(0, 7) != 0, $urandom_range(0, 15) == 0);
    @(negedge clk_12MHz);
    checkAllOutputs();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
